// File: rtl/axi_tb_pkg.sv
`default_nettype none
// ============================================================================
// Module  : axi_tb_pkg
// Purpose : Shared types and constants for the AXI test-harness channel
//           sequencer. It holds the channel index map, the AXI response
//           encoding and the per-channel FSM state type.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package axi_tb_pkg;

  // Bit position of each AXI channel in the per-channel vectors
  localparam int CH_AW = 4;
  localparam int CH_W  = 3;
  localparam int CH_B  = 2;
  localparam int CH_AR = 1;
  localparam int CH_R  = 0;

  typedef enum logic [1:0] {
    OKAY   = 2'd0,
    EXOKAY = 2'd1,
    SLVERR = 2'd2,
    DECERR = 2'd3
  } resp_t;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } ch_state_t;

endpackage
`default_nettype wire

// File: rtl/axi_tb_chan_slot.sv
`default_nettype none
// ============================================================================
// Module  : axi_tb_chan_slot
// Purpose : One sequencer channel. It contains a stimulus FIFO, the
//           IDLE/ACTIVE transfer FSM, a timeout counter and the capture and
//           completion registers.
// Ports   : clk, rst_n, clr        - clock, async active-low reset, sync clear
//           push, push_data        - qualified push (already gated by ready)
//           ready                  - FIFO not full
//           tx_en, tx_data         - registered transfer enable and payload
//           done, resp, rx_data    - completion pulse and sampled response/data
//           cap_data, done_cnt     - last captured data, saturating completions
//           err                    - this cycle completes with a non-OKAY resp
//           timeout_flag           - sticky timeout indication
//           slot_idle              - FIFO empty and FSM in IDLE
// Rev     : 1.0  initial release
// ============================================================================
module axi_tb_chan_slot
  import axi_tb_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  output logic              ready,
  output logic              tx_en,
  output logic [DATA_W-1:0] tx_data,
  input  logic              done,
  input  logic [1:0]        resp,
  input  logic [DATA_W-1:0] rx_data,
  output logic [DATA_W-1:0] cap_data,
  output logic [CNT_W-1:0]  done_cnt,
  output logic              err,
  output logic              timeout_flag,
  output logic              slot_idle
);

  localparam int AW = $clog2(DEPTH);
  // The counter only has to hold 0 .. TIMEOUT-1
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;

  ch_state_t         state;
  ch_state_t         state_next;
  logic [TW-1:0]     tmo_cnt;
  logic              tmo_hit;
  logic              pop;
  logic              complete;
  logic              expire;

  assign ready     = (count != FULL_CNT);
  assign tmo_hit   = (TIMEOUT != 0) && (tmo_cnt == TMO_LAST);
  assign tx_en     = (state == ACTIVE);
  assign slot_idle = (state == IDLE) && (count == '0);

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else if (clr) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic. A completion in the same cycle as the timeout
  // still returns to IDLE, and the output logic treats it as a completion.
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (count != '0)      state_next = ACTIVE;
      ACTIVE:  if (done || tmo_hit)  state_next = IDLE;
      default:                       state_next = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: output / event decode
  // --------------------------------------------------------------------------
  always_comb begin
    pop      = (state == IDLE) && (count != '0);
    complete = (state == ACTIVE) && done;
    expire   = (state == ACTIVE) && !done && tmo_hit;
    err      = complete && (resp_t'(resp) != OKAY);
  end

  // --------------------------------------------------------------------------
  // FIFO storage. This storage needs no reset because the pointers define
  // which words are valid.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  // --------------------------------------------------------------------------
  // Transfer payload, timeout counter, capture and status registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_data      <= '0;
      tmo_cnt      <= '0;
      cap_data     <= '0;
      done_cnt     <= '0;
      timeout_flag <= 1'b0;
    end else if (clr) begin
      tx_data      <= '0;
      tmo_cnt      <= '0;
      cap_data     <= '0;
      done_cnt     <= '0;
      timeout_flag <= 1'b0;
    end else begin
      if (pop) begin
        tx_data <= mem[rd_ptr];
        tmo_cnt <= '0;
      end else if ((state == ACTIVE) && !tmo_hit) begin
        tmo_cnt <= tmo_cnt + 1'b1;
      end
      if (complete) begin
        cap_data <= rx_data;
        if (done_cnt != '1) done_cnt <= done_cnt + 1'b1;
      end
      if (expire) timeout_flag <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/axi_tb_chan_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : axi_tb_chan_sequencer
// Purpose : Per-channel AXI stimulus sequencer. It queues payloads for each
//           channel and runs one tx_en transfer at a time per channel, ending
//           on a done pulse or a timeout. It also captures received data and
//           keeps completion and error counts.
// Ports   : ACLK, ARESETn, clr               - clock, async reset, sync clear
//           push_valid/ch/data, push_ready   - stimulus push handshake
//           tx_en, tx_data                   - per-channel transfer drive
//           done, resp, rx_data              - per-channel completion inputs
//           cap_data, done_cnt, err_cnt      - captured data and counters
//           timeout, idle                    - status
// Rev     : 1.0  initial release
// ============================================================================
module axi_tb_chan_sequencer
  import axi_tb_pkg::*;
#(
  parameter int NUM_CH  = 5,
  parameter int DATA_W  = 64,
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 64,
  localparam int CH_IW  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     ACLK,
  input  logic                     ARESETn,
  input  logic                     clr,
  input  logic                     push_valid,
  input  logic [CH_IW-1:0]         push_ch,
  input  logic [DATA_W-1:0]        push_data,
  output logic                     push_ready,
  output logic [NUM_CH-1:0]        tx_en,
  output logic [NUM_CH*DATA_W-1:0] tx_data,
  input  logic [NUM_CH-1:0]        done,
  input  logic [2*NUM_CH-1:0]      resp,
  input  logic [NUM_CH*DATA_W-1:0] rx_data,
  output logic [NUM_CH*DATA_W-1:0] cap_data,
  output logic [NUM_CH*CNT_W-1:0]  done_cnt,
  output logic [CNT_W-1:0]         err_cnt,
  output logic [NUM_CH-1:0]        timeout,
  output logic                     idle
);

  localparam int EW = $clog2(NUM_CH + 1);

  logic [NUM_CH-1:0] ch_match;
  logic [NUM_CH-1:0] slot_ready;
  logic [NUM_CH-1:0] slot_err;
  logic [NUM_CH-1:0] slot_idle;
  logic [EW-1:0]     err_sum;
  logic [CNT_W:0]    err_ext;
  logic [CNT_W-1:0]  err_next;

  // An out-of-range push_ch matches no slot, so push_ready stays low and
  // the push is dropped.
  assign push_ready = |(ch_match & slot_ready);
  assign idle       = &slot_idle;

  generate
    for (genvar i = 0; i < NUM_CH; i++) begin : g_slot
      assign ch_match[i] = (push_ch == CH_IW'(i));

      axi_tb_chan_slot #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .CNT_W   (CNT_W),
        .TIMEOUT (TIMEOUT)
      ) u_slot (
        .clk          (ACLK),
        .rst_n        (ARESETn),
        .clr          (clr),
        .push         (push_valid & ch_match[i] & slot_ready[i]),
        .push_data    (push_data),
        .ready        (slot_ready[i]),
        .tx_en        (tx_en[i]),
        .tx_data      (tx_data[i*DATA_W +: DATA_W]),
        .done         (done[i]),
        .resp         (resp[2*i +: 2]),
        .rx_data      (rx_data[i*DATA_W +: DATA_W]),
        .cap_data     (cap_data[i*DATA_W +: DATA_W]),
        .done_cnt     (done_cnt[i*CNT_W +: CNT_W]),
        .err          (slot_err[i]),
        .timeout_flag (timeout[i]),
        .slot_idle    (slot_idle[i])
      );
    end
  endgenerate

  // Several channels can report errors in the same cycle. They are all
  // added at once, and the sum saturates at all-ones.
  always_comb begin
    err_sum = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      err_sum = err_sum + EW'(slot_err[i]);
    end
    err_ext  = {1'b0, err_cnt} + (CNT_W + 1)'(err_sum);
    err_next = err_ext[CNT_W] ? '1 : err_ext[CNT_W-1:0];
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      err_cnt <= '0;
    end else if (clr) begin
      err_cnt <= '0;
    end else begin
      err_cnt <= err_next;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_tb_chan_sequencer.sv
`default_nettype none
// ============================================================================
// Module  : tb_axi_tb_chan_sequencer
// Purpose : Self-checking bench for axi_tb_chan_sequencer. A queue-based
//           reference model tracks every channel. Directed scenarios are
//           followed by a randomized phase.
// Rev     : 1.0  initial release
// ============================================================================
module tb_axi_tb_chan_sequencer;

  localparam int NUM_CH  = 5;
  localparam int DATA_W  = 64;
  localparam int DEPTH   = 4;
  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 8;
  localparam int VW      = NUM_CH * DATA_W;

  logic                     ACLK;
  logic                     ARESETn;
  logic                     clr;
  logic                     push_valid;
  logic [2:0]               push_ch;
  logic [DATA_W-1:0]        push_data;
  logic                     push_ready;
  logic [NUM_CH-1:0]        tx_en;
  logic [VW-1:0]            tx_data;
  logic [NUM_CH-1:0]        done;
  logic [2*NUM_CH-1:0]      resp;
  logic [VW-1:0]            rx_data;
  logic [VW-1:0]            cap_data;
  logic [NUM_CH*CNT_W-1:0]  done_cnt;
  logic [CNT_W-1:0]         err_cnt;
  logic [NUM_CH-1:0]        timeout;
  logic                     idle;

  int checks   = 0;
  int failures = 0;

  axi_tb_chan_sequencer #(
    .NUM_CH  (NUM_CH),
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .CNT_W   (CNT_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .ACLK       (ACLK),
    .ARESETn    (ARESETn),
    .clr        (clr),
    .push_valid (push_valid),
    .push_ch    (push_ch),
    .push_data  (push_data),
    .push_ready (push_ready),
    .tx_en      (tx_en),
    .tx_data    (tx_data),
    .done       (done),
    .resp       (resp),
    .rx_data    (rx_data),
    .cap_data   (cap_data),
    .done_cnt   (done_cnt),
    .err_cnt    (err_cnt),
    .timeout    (timeout),
    .idle       (idle)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  // ---------------- reference model ----------------
  logic [DATA_W-1:0] mq [NUM_CH][$];
  logic [DATA_W-1:0] m_cur [NUM_CH];
  logic [DATA_W-1:0] m_cap [NUM_CH];
  int                m_age [NUM_CH];
  int                m_dcnt [NUM_CH];
  logic [NUM_CH-1:0] m_active;
  logic [NUM_CH-1:0] m_tmo;
  int                m_err;

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      mq[i].delete();
      m_cur[i]  = '0;
      m_cap[i]  = '0;
      m_age[i]  = 0;
      m_dcnt[i] = 0;
    end
    m_active = '0;
    m_tmo    = '0;
    m_err    = 0;
  endtask

  function automatic logic exp_ready();
    if (int'(push_ch) >= NUM_CH) return 1'b0;
    return mq[push_ch].size() < DEPTH;
  endfunction

  // Apply one clock edge worth of behaviour using the pre-edge inputs
  task automatic model_edge();
    logic acc;
    int   k;
    if (clr) begin
      model_reset();
      return;
    end
    acc = exp_ready() && push_valid;
    k = 0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (m_active[i]) begin
        if (done[i]) begin
          m_cap[i] = rx_data[i*DATA_W +: DATA_W];
          if (m_dcnt[i] < 65535) m_dcnt[i]++;
          if (resp[2*i +: 2] != 2'b00) k++;
          m_active[i] = 1'b0;
        end else begin
          m_age[i]++;
          if (m_age[i] == TIMEOUT) begin
            m_tmo[i]    = 1'b1;
            m_active[i] = 1'b0;
          end
        end
      end else if (mq[i].size() > 0) begin
        m_cur[i]    = mq[i].pop_front();
        m_active[i] = 1'b1;
        m_age[i]    = 0;
      end
    end
    m_err = (m_err + k > 65535) ? 65535 : m_err + k;
    if (acc) mq[push_ch].push_back(push_data);
  endtask

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all(input string tag);
    logic [VW-1:0]           e_txd, a_txd, e_cap;
    logic [NUM_CH*CNT_W-1:0] e_dc;
    logic                    e_idle;
    e_txd  = '0;
    a_txd  = '0;
    e_idle = (m_active == '0);
    for (int i = 0; i < NUM_CH; i++) begin
      if (m_active[i]) begin
        e_txd[i*DATA_W +: DATA_W] = m_cur[i];
        a_txd[i*DATA_W +: DATA_W] = tx_data[i*DATA_W +: DATA_W];
      end
      e_cap[i*DATA_W +: DATA_W] = m_cap[i];
      e_dc[i*CNT_W +: CNT_W]    = CNT_W'(m_dcnt[i]);
      if (mq[i].size() != 0) e_idle = 1'b0;
    end
    check({tag, ":tx_en"},    tx_en,    m_active);
    check({tag, ":tx_data"},  a_txd,    e_txd);
    check({tag, ":cap_data"}, cap_data, e_cap);
    check({tag, ":done_cnt"}, done_cnt, e_dc);
    check({tag, ":err_cnt"},  err_cnt,  CNT_W'(m_err));
    check({tag, ":timeout"},  timeout,  m_tmo);
    check({tag, ":idle"},     idle,     e_idle);
  endtask

  // One clock: check push_ready pre-edge, advance model, compare post-edge
  task automatic cycle(input string tag);
    #1;
    check({tag, ":push_ready"}, push_ready, exp_ready());
    model_edge();
    @(posedge ACLK);
    #1;
    compare_all(tag);
    @(negedge ACLK);
  endtask

  task automatic rand_rx();
    for (int i = 0; i < VW / 32; i++) rx_data[i*32 +: 32] = $urandom;
  endtask

  task automatic push1(input logic [2:0] ch, input logic [DATA_W-1:0] d, input string tag);
    push_valid = 1'b1;
    push_ch    = ch;
    push_data  = d;
    cycle(tag);
    push_valid = 1'b0;
  endtask

  // Safety net so the run always terminates
  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi;
    ARESETn    = 1'b0;
    clr        = 1'b0;
    push_valid = 1'b0;
    push_ch    = '0;
    push_data  = '0;
    done       = '0;
    resp       = '0;
    rx_data    = '0;
    model_reset();
    #2;
    compare_all("reset");
    check("reset_tx_data", tx_data, '0);
    check("reset_idle", idle, 1'b1);
    @(negedge ACLK);
    ARESETn = 1'b1;

    // --- single transfer on AW ---
    push1(3'd4, 64'h1000, "tp1_push");
    cycle("tp1_pop");
    check("tp1_tx_en", tx_en, 5'b10000);
    check("tp1_tx_data", tx_data[4*DATA_W +: DATA_W], 64'h1000);
    cycle("tp1_wait");
    cycle("tp1_wait");
    done = 5'b10000;
    resp = '0;
    rand_rx();
    cycle("tp1_done");
    done = '0;
    check("tp1_tx_en_off", tx_en[4], 1'b0);
    check("tp1_done_cnt", done_cnt[4*CNT_W +: CNT_W], 16'd1);
    check("tp1_err_cnt", err_cnt, 16'd0);

    // --- fill W channel, then drain in order ---
    for (int k = 0; k < 5; k++) push1(3'd3, 64'h3000 + 64'(k), "tp2_push");
    push_valid = 1'b1;
    push_ch    = 3'd3;
    push_data  = 64'hdead;
    #1;
    check("tp2_full_ready", push_ready, 1'b0);
    cycle("tp2_refused");
    push_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      for (int w = 0; w < 10 && !m_active[3]; w++) cycle("tp2_wait");
      check("tp2_active", tx_en[3], 1'b1);
      check("tp2_order", tx_data[3*DATA_W +: DATA_W], 64'h3000 + 64'(k));
      done[3] = 1'b1;
      rand_rx();
      cycle("tp2_done");
      done[3] = 1'b0;
      check("tp2_gap", tx_en[3], 1'b0);
    end

    // --- simultaneous errors on AR and R ---
    push1(3'd1, 64'haaaa, "tp3_push1");
    push1(3'd0, 64'hbbbb, "tp3_push0");
    cycle("tp3_pop");
    check("tp3_both_active", tx_en[1:0], 2'b11);
    done = 5'b00011;
    resp = 10'b00000_01010;
    rand_rx();
    cycle("tp3_done");
    done = '0;
    resp = '0;
    check("tp3_err_cnt", err_cnt, 16'd2);
    check("tp3_done_cnt1", done_cnt[1*CNT_W +: CNT_W], 16'd1);
    check("tp3_done_cnt0", done_cnt[0*CNT_W +: CNT_W], 16'd1);

    // --- timeout on B ---
    push1(3'd2, 64'hc001, "tp4_push");
    push1(3'd2, 64'hc002, "tp4_push");
    hi = tx_en[2] ? 1 : 0;
    for (int w = 0; w < 20 && tx_en[2]; w++) begin
      cycle("tp4_run");
      if (tx_en[2]) hi++;
    end
    check("tp4_len", 32'(hi), 32'd8);
    check("tp4_flag", timeout[2], 1'b1);
    check("tp4_done_cnt", done_cnt[2*CNT_W +: CNT_W], 16'd0);
    cycle("tp4_next");
    check("tp4_next_en", tx_en[2], 1'b1);
    check("tp4_next_data", tx_data[2*DATA_W +: DATA_W], 64'hc002);
    for (int w = 0; w < 12; w++) cycle("tp4_drain");
    check("tp4_sticky", timeout[2], 1'b1);

    // --- out-of-range channel ---
    check("tp5_idle_before", idle, 1'b1);
    push_valid = 1'b1;
    push_ch    = 3'd5;
    push_data  = 64'h5555;
    #1;
    check("tp5_ready", push_ready, 1'b0);
    cycle("tp5_push");
    push_valid = 1'b0;
    cycle("tp5_after");
    check("tp5_idle_after", idle, 1'b1);

    // --- async reset mid-transfer ---
    for (int k = 0; k < 4; k++) push1(3'd4, 64'h4400 + 64'(k), "tp6_push");
    check("tp6_active", tx_en[4], 1'b1);
    #2;
    ARESETn = 1'b0;
    #1;
    model_reset();
    compare_all("tp6_reset");
    check("tp6_tx_en", tx_en, 5'b0);
    check("tp6_idle", idle, 1'b1);
    @(negedge ACLK);
    ARESETn = 1'b1;
    for (int w = 0; w < 5; w++) cycle("tp6_quiet");
    check("tp6_no_tx", tx_en, 5'b0);

    // --- sync clear wins over a simultaneous push ---
    push1(3'd0, 64'h0101, "tp7_push");
    push1(3'd1, 64'h0202, "tp7_push");
    clr        = 1'b1;
    push_valid = 1'b1;
    push_ch    = 3'd2;
    cycle("tp7_clr");
    clr        = 1'b0;
    push_valid = 1'b0;
    check("tp7_idle", idle, 1'b1);
    check("tp7_tx_en", tx_en, 5'b0);

    // --- randomized traffic ---
    for (int n = 0; n < 400; n++) begin
      push_valid = 1'($urandom);
      push_ch    = 3'($urandom);
      push_data  = {$urandom, $urandom};
      done       = 5'($urandom) & 5'($urandom);
      resp       = 10'($urandom);
      rand_rx();
      clr        = ($urandom_range(0, 99) == 0);
      cycle("rand");
    end
    push_valid = 1'b0;
    done       = '0;
    clr        = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
